sb_rx_msg_queue: RTL and testbench
==================================

Name: sb_rx_msg_queue

Overview:
- Receive-side sideband message queue between the SB deserializer/decoder (upstream) and the LTSM state blocks (downstream).
- Downstream consumers are SBINIT, MBINIT and the other state blocks.
- Buffers decoded SB messages and their 64-bit data payloads in arrival order.
- Presents messages to the active LTSM state through the available/req/valid pull handshake those states already use.
- Flags overflow and supports flush on LTSM state change.

Parameters:
DEPTH, 4, number of message entries; power of two, 2..16.
DATA_W, 64, payload width in bits.

Ports:
clk_100MHz  input  1  sideband-domain clock
reset_n  input  1  asynchronous active-low reset
in_msg_i  input  SB_msg_t  decoded message header from SB deserializer
in_data_i  input  DATA_W  payload; zero for messages without data
in_valid_i  input  1  one-cycle push strobe
flush_i  input  1  synchronous clear of all stored entries
SB_RX_msg_available_o  output  1  queue non-empty
SB_RX_msg_req_i  input  1  consumer pull request (level)
SB_RX_msg_o  output  SB_msg_t  head message, held after pop
SB_RX_dataBus_o  output  DATA_W  head payload, held after pop
SB_RX_msg_valid_o  output  1  one-cycle strobe; outputs valid this cycle
occupancy_o  output  $clog2(DEPTH)+1  stored entry count
overflow_o  output  1  sticky; a push was dropped while full
drop_count_o  output  8  saturating count of dropped pushes

Behaviour:
- All state updates on the rising edge of clk_100MHz. reset_n low clears asynchronously:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - SB_RX_msg_o = reset_SB_msg(), SB_RX_dataBus_o = 0, SB_RX_msg_valid_o = 0.
  - available = 0, overflow = 0, drop_count = 0.
- Storage: circular buffer of DEPTH entries, each {SB_msg_t, DATA_W}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is 0..DEPTH.
- Push: in_valid_i && (count < DEPTH || pop this cycle).
  - Write the entry at wr_ptr and increment wr_ptr.
  - Push when full with no pop: entry dropped, overflow_o set (sticky), drop_count_o incremented, saturating at 255. Stored contents unchanged.
- Pop: SB_RX_msg_req_i && count != 0 && !SB_RX_msg_valid_o && !flush_i.
  - Registered: head entry driven onto SB_RX_msg_o/SB_RX_dataBus_o with SB_RX_msg_valid_o = 1 on the next cycle. rd_ptr increments.
  - Latency from req sample to valid is 1 cycle.
- Guard: req is ignored in any cycle where SB_RX_msg_valid_o = 1. Consumers deregister req one cycle after seeing valid, so this guard prevents a double pop.
- SB_RX_msg_valid_o is a single-cycle pulse. SB_RX_msg_o/SB_RX_dataBus_o hold the last popped value until the next pop.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed when full: the freed slot accepts the push, no drop.
  - Allowed when count == 0? No: pop needs count != 0 at sample time. The push lands and is poppable the next cycle.
- SB_RX_msg_available_o is registered and equals (next count != 0). It deasserts in the same cycle valid pulses when the last entry is popped.
- occupancy_o is registered and equals count.
- flush_i:
  - Clears pointers and count next cycle. A push in the same cycle is discarded, not counted as a drop.
  - Suppresses pop.
  - Does not clear overflow_o or drop_count_o; only reset_n clears those.
  - A valid pulse already scheduled from the previous cycle still completes.
- Reset mid-pop: valid is cleared immediately; the entry is lost. No other recovery.
- No FSM beyond the pop guard. Sequential elements: pointers, count, output register, flags.

Decomposition:
- SB_msg_t, reset_SB_msg() and message enums are reused from SB_codex_pkg; no new typedefs.
- Add SB_RX_QUEUE_DEPTH_DEFAULT (4) to SB_codex_pkg.
- One natural sub-module: sb_fifo_mem, a DEPTH x ($bits(SB_msg_t)+DATA_W) register array with write port and combinational read. Pointer/count/handshake control stays in sb_rx_msg_queue.

Test Plan:
1. Push SBINIT_out_of_reset, data 0; hold req high until valid, dropping req the cycle after valid (SBINIT style) -> exactly one valid pulse 1 cycle after first req sample, msg_num matches; available 1->0; occupancy 1->0; no second pop.
2. Push 4 messages back-to-back with DEPTH=4; push a 5th -> occupancy 4, overflow_o=1, drop_count_o=1; pops return msgs 1-4 in order with data 0x1111...,0x2222... intact.
3. Full queue: push and pop in the same cycle -> no drop, occupancy stays 4, popped order preserved, new entry returned last.
4. Assert req continuously for 3 stored entries -> valid pulses at cycles t+1, t+3, t+5 (guard cycle between each); occupancy 3,2,1,0.
5. Push 3 entries, assert flush_i together with a push and req -> occupancy 0 next cycle, available 0, no valid pulse, overflow/drop_count unchanged.
6. Drop reset_n low asynchronously mid-cycle with 2 entries and a pending valid -> all outputs at reset values immediately, before the next clock edge; after release, new pushes start at entry 0.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// Sideband codex definitions shared by the SB TX/RX datapaths and the LTSM
// state blocks: message numbers, the decoded message header, its reset value
// and the default depth of the receive message queue.
package SB_codex_pkg;

    localparam int SB_RX_QUEUE_DEPTH_DEFAULT = 4;

    typedef enum logic [4:0] {
        SB_MSG_NONE                     = 5'd0,
        SBINIT_out_of_reset             = 5'd1,
        SBINIT_done_req                 = 5'd2,
        SBINIT_done_resp                = 5'd3,
        MBINIT_PARAM_configuration_req  = 5'd4,
        MBINIT_PARAM_configuration_resp = 5'd5,
        MBINIT_CAL_Done_req             = 5'd6,
        MBINIT_CAL_Done_resp            = 5'd7,
        MBINIT_REPAIRCLK_init_req       = 5'd8,
        MBINIT_REPAIRCLK_init_resp      = 5'd9
    } SB_msg_num_e;

    typedef struct packed {
        SB_msg_num_e msg_num;
        logic [15:0] msg_info;
        logic        data_present;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_num      = SB_MSG_NONE;
        m.msg_info     = '0;
        m.data_present = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/sb_fifo_mem.sv
// Register-array storage for the SB receive queue.
// Ports:
//   clk_100MHz  write clock
//   wr_en       write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr     write entry index
//   wr_data     entry to store
//   rd_addr     read entry index
//   rd_data     entry at rd_addr, combinational
module sb_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 86
) (
    input  logic                     clk_100MHz,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sb_rx_msg_queue.sv
// Receive-side sideband message queue. Buffers decoded SB messages and their
// payloads in arrival order and hands them to the active LTSM state through
// the available/req/valid pull handshake.
// Ports:
//   clk_100MHz              sideband-domain clock
//   reset_n                 asynchronous active-low reset
//   in_msg_i/in_data_i      decoded header and payload from the deserializer
//   in_valid_i              one-cycle push strobe
//   flush_i                 synchronous clear of all stored entries
//   SB_RX_msg_available_o   queue non-empty (registered)
//   SB_RX_msg_req_i         consumer pull request (level)
//   SB_RX_msg_o             head message, held after pop
//   SB_RX_dataBus_o         head payload, held after pop
//   SB_RX_msg_valid_o       one-cycle strobe marking a popped entry
//   occupancy_o             stored entry count
//   overflow_o              sticky, a push was dropped while full
//   drop_count_o            saturating count of dropped pushes
module sb_rx_msg_queue
    import SB_codex_pkg::*;
#(
    parameter int DEPTH  = SB_RX_QUEUE_DEPTH_DEFAULT,
    parameter int DATA_W = 64
) (
    input  logic                   clk_100MHz,
    input  logic                   reset_n,
    input  SB_msg_t                in_msg_i,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic                   in_valid_i,
    input  logic                   flush_i,
    output logic                   SB_RX_msg_available_o,
    input  logic                   SB_RX_msg_req_i,
    output SB_msg_t                SB_RX_msg_o,
    output logic [DATA_W-1:0]      SB_RX_dataBus_o,
    output logic                   SB_RX_msg_valid_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   overflow_o,
    output logic [7:0]             drop_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MSG_W = $bits(SB_msg_t);
    localparam int ENT_W = MSG_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             pop;
    logic             push;
    logic             drop;
    logic [ENT_W-1:0] rd_entry;

    sb_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk_100MHz (clk_100MHz),
        .wr_en      (push),
        .wr_addr    (wr_ptr),
        .wr_data    ({in_msg_i, in_data_i}),
        .rd_addr    (rd_ptr),
        .rd_data    (rd_entry)
    );

    // Consumers drop req one cycle after seeing valid, so req is ignored while
    // valid is high; that is the whole pop guard. A full queue still accepts a
    // push when the head is leaving in the same cycle.
    always_comb begin
        pop  = SB_RX_msg_req_i && (count != '0) && !SB_RX_msg_valid_o && !flush_i;
        push = in_valid_i && !flush_i && ((count != FULL_CNT) || pop);
        drop = in_valid_i && !flush_i && (count == FULL_CNT) && !pop;

        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // A valid pulse scheduled before a flush still completes because the
    // output register is loaded only on pop and otherwise holds.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            SB_RX_msg_o           <= reset_SB_msg();
            SB_RX_dataBus_o       <= '0;
            SB_RX_msg_valid_o     <= 1'b0;
            SB_RX_msg_available_o <= 1'b0;
            overflow_o            <= 1'b0;
            drop_count_o          <= '0;
        end else begin
            SB_RX_msg_valid_o     <= pop;
            SB_RX_msg_available_o <= (count_next != '0);
            if (pop) begin
                SB_RX_msg_o     <= SB_msg_t'(rd_entry[ENT_W-1:DATA_W]);
                SB_RX_dataBus_o <= rd_entry[DATA_W-1:0];
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 8'hFF) begin
                    drop_count_o <= drop_count_o + 8'd1;
                end
            end
        end
    end

    assign occupancy_o = count;

endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Scoreboard bench for sb_rx_msg_queue: a queue-based reference model predicts
// every pop, the monitor checks each valid pulse and the status outputs.
module tb_sb_rx_msg_queue;
    import SB_codex_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    typedef struct packed {
        SB_msg_t           msg;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk_100MHz = 1'b0;
    logic              reset_n    = 1'b0;
    SB_msg_t           in_msg     = '0;
    logic [DATA_W-1:0] in_data    = '0;
    logic              in_valid   = 1'b0;
    logic              flush      = 1'b0;
    logic              req        = 1'b0;
    logic              available;
    SB_msg_t           out_msg;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [2:0]        occupancy;
    logic              overflow;
    logic [7:0]        drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    sb_rx_msg_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_100MHz            (clk_100MHz),
        .reset_n               (reset_n),
        .in_msg_i              (in_msg),
        .in_data_i             (in_data),
        .in_valid_i            (in_valid),
        .flush_i               (flush),
        .SB_RX_msg_available_o (available),
        .SB_RX_msg_req_i       (req),
        .SB_RX_msg_o           (out_msg),
        .SB_RX_dataBus_o       (out_data),
        .SB_RX_msg_valid_o     (out_valid),
        .occupancy_o           (occupancy),
        .overflow_o            (overflow),
        .drop_count_o          (drop_count)
    );

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored entries as a plain queue, pops produce expected
    // entries for the monitor.
    ent_t m_q[$];
    ent_t exp_q[$];
    bit   m_valid;
    bit   m_over;
    int   m_drops;
    ent_t last;

    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            exp_q.delete();
            m_valid  = 1'b0;
            m_over   = 1'b0;
            m_drops  = 0;
            last.msg = reset_SB_msg();
            last.data = '0;
        end else begin
            bit   do_pop;
            ent_t e;
            do_pop = req && (m_q.size() > 0) && !m_valid && !flush;
            if (do_pop) exp_q.push_back(m_q.pop_front());
            m_valid = do_pop;
            if (flush) begin
                m_q.delete();
            end else if (in_valid) begin
                if (m_q.size() < DEPTH) begin
                    e.msg  = in_msg;
                    e.data = in_data;
                    m_q.push_back(e);
                end else begin
                    m_over = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk_100MHz) begin
        if (reset_n) begin
            ent_t e;
            cmp("valid", 128'(out_valid), 128'(m_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got msg %0h expected no pop at %0t", out_msg, $time);
                end else begin
                    e = exp_q.pop_front();
                    cmp("pop_msg", 128'(out_msg), 128'(e.msg));
                    cmp("pop_data", 128'(out_data), 128'(e.data));
                    last = e;
                end
            end else begin
                cmp("held_msg", 128'(out_msg), 128'(last.msg));
                cmp("held_data", 128'(out_data), 128'(last.data));
            end
            cmp("occupancy", 128'(occupancy), 128'(m_q.size()));
            cmp("available", 128'(available), 128'(m_q.size() != 0));
            cmp("overflow", 128'(overflow), 128'(m_over));
            cmp("drop_count", 128'(drop_count), 128'(m_drops));
        end
    end

    function automatic SB_msg_t mk(input SB_msg_num_e n, input logic [15:0] info, input logic dp);
        SB_msg_t m;
        m.msg_num      = n;
        m.msg_info     = info;
        m.data_present = dp;
        return m;
    endfunction

    task automatic step(input bit v, input SB_msg_t m, input logic [DATA_W-1:0] d,
                        input bit r, input bit f);
        in_valid = v;
        in_msg   = m;
        in_data  = d;
        req      = r;
        flush    = f;
        @(negedge clk_100MHz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, reset_SB_msg(), '0, 1'b0, 1'b0);
    endtask

    task automatic pull(input int n);
        for (int i = 0; i < n; i++) step(1'b0, reset_SB_msg(), '0, 1'b1, 1'b0);
    endtask

    task automatic push_k(input int k, input bit r);
        step(1'b1, mk(SB_msg_num_e'(5'(k)), 16'(k * 3), 1'b1), {16{4'(k)}}, r, 1'b0);
    endtask

    task automatic check_reset_outputs();
        cmp("rst_valid", 128'(out_valid), 128'(0));
        cmp("rst_msg", 128'(out_msg), 128'(reset_SB_msg()));
        cmp("rst_data", 128'(out_data), 128'(0));
        cmp("rst_available", 128'(available), 128'(0));
        cmp("rst_occupancy", 128'(occupancy), 128'(0));
        cmp("rst_overflow", 128'(overflow), 128'(0));
        cmp("rst_drop_count", 128'(drop_count), 128'(0));
    endtask

    initial begin
        bit seen;
        #1;
        check_reset_outputs();
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        idle(2);

        // SBINIT-style consumer: req until valid, drop it the cycle after
        step(1'b1, mk(SBINIT_out_of_reset, 16'h0, 1'b0), '0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, reset_SB_msg(), '0, 1'b1, 1'b0);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sbinit_wait: got no valid expected valid within 10 cycles");
        end
        pull(1);
        idle(3);

        // Fill past full: fifth push dropped, then drain in order
        for (int k = 1; k <= 5; k++) push_k(k, 1'b0);
        pull(10);
        idle(2);

        // Full queue with simultaneous push and pop
        for (int k = 1; k <= 4; k++) push_k(k, 1'b0);
        push_k(10, 1'b1);
        pull(12);
        idle(2);

        // Continuous req over three entries: guard cycle between pulses
        for (int k = 6; k <= 8; k++) push_k(k, 1'b0);
        pull(8);
        idle(2);

        // Flush together with push and req
        for (int k = 1; k <= 3; k++) push_k(k, 1'b0);
        step(1'b1, mk(MBINIT_CAL_Done_req, 16'hBEEF, 1'b1), 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1);
        idle(3);

        // Asynchronous reset right after a pop was launched
        push_k(2, 1'b0);
        push_k(3, 1'b0);
        req = 1'b1;
        @(posedge clk_100MHz);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        req = 1'b0;
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        push_k(4, 1'b0);
        push_k(5, 1'b0);
        pull(6);
        idle(2);

        // Drop counter saturation
        for (int i = 0; i < 265; i++) push_k((i % 9) + 1, 1'b0);
        pull(10);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 mk(SB_msg_num_e'(5'($urandom_range(1, 9))), 16'($urandom), 1'($urandom)),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
